// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding, byte width,
// default hold limit and a constant-friendly ceil(log2) helper.
// No logic; imported by the arbiter, its round-robin picker and the bus interface.
package uart_pkg;

  localparam int BYTE_W         = 8;
  localparam int HOLD_LIMIT_DEF = 1024;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_BUSY = S_BUSY,
    ST_HOLD = S_HOLD
  } arb_state_t;

  // Ceil(log2(value)), never less than 1 so a vector built from it is legal.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the requesters / Transmitter and the transmit arbiter.
// Pure wiring, no latency.
// Requesters hold REQ until ACK; the Transmitter signals completion with DONE.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  import uart_pkg::*;

  logic [NREQ-1:0]        REQ;
  logic [BYTE_W*NREQ-1:0] DATA;
  logic [NREQ-1:0]        LAST;
  logic [NREQ-1:0]        ACK;
  logic [NREQ-1:0]        GNT;
  logic                   TIMEOUT;
  logic                   TXSTART;
  logic [BYTE_W-1:0]      LINEIN;
  logic                   DONE;

  // Arbiter side.
  modport master (
    input  REQ, DATA, LAST, DONE,
    output ACK, GNT, TIMEOUT, TXSTART, LINEIN
  );

  // Requester / Transmitter side.
  modport slave (
    output REQ, DATA, LAST, DONE,
    input  ACK, GNT, TIMEOUT, TXSTART, LINEIN
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request after ptr, wrapping.
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is used.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [PW-1:0]   win_idx
);

  logic          found;
  logic [PW-1:0] cand;

  // Scan ptr+1, ptr+2, ... and keep only the first requester found.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found         = 1'b1;
        win_oh[cand]  = 1'b1;
        win_idx       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one UART Transmitter among NREQ requesters.
// Latency: REQ sampled at edge t gives TXSTART/ACK/LINEIN during t..t+1; next byte no earlier than DONE+1.
// Backpressure: REQ held until ACK; grant locked to owner until LAST byte done or hold timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int HOLD_LIMIT = HOLD_LIMIT_DEF
) (
  input  logic              CLOCK,
  input  logic              RESETN,
  uart_tx_arbiter_if.master bus
);

  localparam int              PW       = clog2(NREQ);
  localparam int              CW       = clog2(HOLD_LIMIT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(HOLD_LIMIT - 1);
  localparam logic [PW-1:0]   PTR_RST  = PW'(NREQ - 1);

  arb_state_t        state_q,   state_d;
  logic [NREQ-1:0]   gnt_q,     gnt_d;
  logic [NREQ-1:0]   ack_q,     ack_d;
  logic [PW-1:0]     ptr_q,     ptr_d;
  logic [BYTE_W-1:0] linein_q,  linein_d;
  logic              last_q,    last_d;
  logic              txstart_q, txstart_d;
  logic              timeout_q, timeout_d;
  logic [CW-1:0]     cnt_q,     cnt_d;

  logic [BYTE_W-1:0] data_b [NREQ];
  logic [NREQ-1:0]   pick_oh;
  logic [PW-1:0]     pick_idx;

  // Split the flattened data bus into one byte per requester.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      data_b[i] = bus.DATA[i*BYTE_W +: BYTE_W];
    end
  end

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req     (bus.REQ),
    .ptr     (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx)
  );

  // State and output registers; reset clears everything and gives requester 0 first priority.
  always_ff @(posedge CLOCK) begin
    if (!RESETN) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      ack_q     <= '0;
      ptr_q     <= PTR_RST;
      linein_q  <= '0;
      last_q    <= 1'b0;
      txstart_q <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      ptr_q     <= ptr_d;
      linein_q  <= linein_d;
      last_q    <= last_d;
      txstart_q <= txstart_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic: grant in IDLE, wait for DONE in BUSY, owner-only reload or timeout in HOLD.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    ptr_d     = ptr_q;
    linein_d  = linein_q;
    last_d    = last_q;
    txstart_d = 1'b0;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (|bus.REQ) begin
          gnt_d     = pick_oh;
          ptr_d     = pick_idx;
          linein_d  = data_b[pick_idx];
          last_d    = bus.LAST[pick_idx];
          ack_d     = pick_oh;
          txstart_d = 1'b1;
          state_d   = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (bus.DONE) begin
          if (last_q) begin
            gnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        // The owner's index is the pointer, which was set on the original grant.
        if (bus.REQ[ptr_q]) begin
          linein_d  = data_b[ptr_q];
          last_d    = bus.LAST[ptr_q];
          ack_d     = gnt_q;
          txstart_d = 1'b1;
          state_d   = ST_BUSY;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          gnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.ACK     = ack_q;
  assign bus.GNT     = gnt_q;
  assign bus.TIMEOUT = timeout_q;
  assign bus.TXSTART = txstart_q;
  assign bus.LINEIN  = linein_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: byte-queue requesters, a fixed-length Transmitter
// stand-in, a per-cycle reference model and directed literal checks.
// Runs with NREQ=4 and HOLD_LIMIT=8.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NREQ  = 4;
  localparam int HL    = 8;
  localparam int FRAME = 5;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(
    .NREQ       (NREQ),
    .HOLD_LIMIT (HL)
  ) dut (
    .CLOCK  (clk),
    .RESETN (rstn),
    .bus    (bus)
  );

  logic [NREQ-1:0]   req        = '0;
  logic [NREQ-1:0]   last       = '0;
  logic [8*NREQ-1:0] data_flat  = '0;
  logic              tx_done    = 1'b0;
  logic              done_force = 1'b0;
  int                tx_cnt     = 0;

  assign bus.REQ  = req;
  assign bus.LAST = last;
  assign bus.DATA = data_flat;
  assign bus.DONE = tx_done | done_force;

  logic [8:0] cq [NREQ][$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_edge = -100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int r, input logic [7:0] b, input logic l);
    cq[r].push_back({l, b});
  endtask

  // Requesters: present the queue head, pop it when ACKed.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (bus.ACK[i] && cq[i].size() > 0) void'(cq[i].pop_front());
        req[i] = (cq[i].size() > 0);
        if (cq[i].size() > 0) begin
          data_flat[i*8 +: 8] = cq[i][0][7:0];
          last[i]             = cq[i][0][8];
        end
      end
    end
  end

  // Transmitter stand-in: DONE pulse a fixed number of cycles after TXSTART.
  initial begin
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (!rstn) tx_cnt = 0;
      else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) tx_done = 1'b1;
      end else if (bus.TXSTART) tx_cnt = FRAME;
    end
  end

  // Reference model: who owns the Transmitter, is a byte in flight, how long idle in hold.
  int              owner    = -1;
  bit              inflight = 1'b0;
  bit              m_last   = 1'b0;
  int              idle_n   = 0;
  int              m_ptr    = NREQ - 1;
  logic [NREQ-1:0] e_ack    = '0;
  logic [NREQ-1:0] e_gnt    = '0;
  logic            e_to     = 1'b0;
  logic            e_ts     = 1'b0;
  logic [7:0]      e_lin    = '0;

  task automatic grant(input int w);
    owner    = w;
    inflight = 1'b1;
    e_lin    = data_flat[w*8 +: 8];
    m_last   = last[w];
    e_ack    = '0;
    e_ack[w] = 1'b1;
    e_gnt    = '0;
    e_gnt[w] = 1'b1;
    e_ts     = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rstn && bus.DONE) done_edge = cyc;
      e_ack = '0;
      e_ts  = 1'b0;
      e_to  = 1'b0;
      if (!rstn) begin
        owner = -1; inflight = 1'b0; m_last = 1'b0; idle_n = 0;
        m_ptr = NREQ - 1; e_gnt = '0; e_lin = '0;
      end else if (owner < 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          int w;
          w = (m_ptr + k) % NREQ;
          if (owner < 0 && req[w]) begin
            grant(w);
            m_ptr = w;
          end
        end
      end else if (inflight) begin
        if (bus.DONE) begin
          inflight = 1'b0;
          idle_n   = 0;
          if (m_last) begin
            owner = -1;
            e_gnt = '0;
          end
        end
      end else if (req[owner]) begin
        grant(owner);
      end else if (idle_n == HL - 1) begin
        e_to  = 1'b1;
        owner = -1;
        e_gnt = '0;
      end else begin
        idle_n++;
      end
    end
  end

  // Compare DUT outputs against the model every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("cycle{ack,gnt,timeout,txstart,linein}",
            32'({bus.ACK, bus.GNT, bus.TIMEOUT, bus.TXSTART, bus.LINEIN}),
            32'({e_ack, e_gnt, e_to, e_ts, e_lin}));
    end
  end

  task automatic wait_tx(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.TXSTART) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_tx: got no TXSTART in 200 cycles, required one");
    end
  endtask

  task automatic wait_timeout(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.TIMEOUT) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_timeout: got no TIMEOUT in 200 cycles, required one");
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.GNT == '0 && req == '0 && cq[0].size() + cq[1].size() + cq[2].size() + cq[3].size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_idle: GNT=%b still busy after 300 cycles, required idle", bus.GNT);
    end
  endtask

  int exp_ord [5] = '{0, 1, 2, 3, 0};
  int exp_byt [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
  int exp3_b  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  int exp3_g  [4] = '{4'b0100, 4'b0100, 4'b0100, 4'b0010};

  initial begin
    bit ok;
    int c0;
    int t_to;

    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("reset_gnt",     32'(bus.GNT),     32'h0);
    check("reset_ack",     32'(bus.ACK),     32'h0);
    check("reset_txstart", 32'(bus.TXSTART), 32'h0);
    check("reset_timeout", 32'(bus.TIMEOUT), 32'h0);
    check("reset_linein",  32'(bus.LINEIN),  32'h0);

    // Single one-byte frame from requester 0.
    @(posedge clk); #1;
    c0 = cyc;
    push(0, 8'hA5, 1'b1);
    wait_tx(ok);
    if (ok) begin
      check("t1_txstart_edge", 32'(cyc - c0), 32'd1);
      check("t1_gnt",          32'(bus.GNT),    32'b0001);
      check("t1_ack",          32'(bus.ACK),    32'b0001);
      check("t1_linein",       32'(bus.LINEIN), 32'hA5);
    end
    wait_idle();
    check("t1_gnt_clear_at_done", 32'(cyc - done_edge), 32'd0);

    // Fresh reset so requester 0 leads; all four requesting gives 0,1,2,3,0.
    @(posedge clk); #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    push(0, 8'h10, 1'b1); push(0, 8'h14, 1'b1);
    push(1, 8'h11, 1'b1); push(2, 8'h12, 1'b1); push(3, 8'h13, 1'b1);
    for (int k = 0; k < 5; k++) begin
      wait_tx(ok);
      if (ok) begin
        check($sformatf("t2_gnt%0d", k),    32'(bus.GNT),    32'(1 << exp_ord[k]));
        check($sformatf("t2_linein%0d", k), 32'(bus.LINEIN), 32'(exp_byt[k]));
        if (k > 0) check($sformatf("t2_gap%0d", k), 32'(cyc - done_edge), 32'd1);
      end
    end
    wait_idle();

    // Requester 2 sends a 3-byte frame while requester 1 keeps requesting.
    @(posedge clk); #1;
    push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h33, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_tx(ok);
      if (k == 0) begin
        @(posedge clk); #1;
        push(1, 8'h44, 1'b1); push(1, 8'h55, 1'b1);
        @(negedge clk);
      end
      if (ok) begin
        check($sformatf("t3_linein%0d", k), 32'(bus.LINEIN), 32'(exp3_b[k]));
        check($sformatf("t3_gnt%0d", k),    32'(bus.GNT),    32'(exp3_g[k]));
      end
    end
    wait_idle();

    // Requester 0 leaves its frame open; hold times out, then pending requester 3 goes.
    @(posedge clk); #1;
    push(0, 8'h66, 1'b0);
    wait_tx(ok);
    if (ok) check("t4_gnt0", 32'(bus.GNT), 32'b0001);
    @(posedge clk); #1;
    push(3, 8'h77, 1'b1);
    wait_timeout(ok);
    t_to = cyc;
    if (ok) begin
      check("t4_timeout_delay", 32'(cyc - done_edge), 32'(HL));
      check("t4_gnt_cleared",   32'(bus.GNT),         32'h0);
    end
    wait_tx(ok);
    if (ok) begin
      check("t4_gnt3",        32'(bus.GNT),    32'b1000);
      check("t4_linein",      32'(bus.LINEIN), 32'h77);
      check("t4_after_to",    32'(cyc - t_to), 32'd1);
    end
    wait_idle();

    // Reset while a byte is in flight, with DONE on the same reset edge.
    @(posedge clk); #1;
    push(2, 8'h88, 1'b1);
    wait_tx(ok);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    done_force = 1'b1;
    for (int i = 0; i < NREQ; i++) cq[i].delete();
    @(posedge clk); #1 done_force = 1'b0;
    @(negedge clk);
    check("t5_gnt",     32'(bus.GNT),     32'h0);
    check("t5_ack",     32'(bus.ACK),     32'h0);
    check("t5_txstart", 32'(bus.TXSTART), 32'h0);
    check("t5_timeout", 32'(bus.TIMEOUT), 32'h0);
    check("t5_linein",  32'(bus.LINEIN),  32'h0);
    @(posedge clk); #1 rstn = 1'b1;
    push(0, 8'h99, 1'b1); push(3, 8'hAA, 1'b1);
    wait_tx(ok);
    if (ok) begin
      check("t5_first_gnt", 32'(bus.GNT),    32'b0001);
      check("t5_first_ack", 32'(bus.ACK),    32'b0001);
      check("t5_linein",    32'(bus.LINEIN), 32'h99);
    end
    wait_tx(ok);
    if (ok) check("t5_second_gnt", 32'(bus.GNT), 32'b1000);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
